// File: rtl/dcache_msq_pkg.sv
// Shared types and defaults for the data-cache miss status queue.
package dcache_msq_pkg;

  localparam int DC_LINE_SIZE_DEFAULT = 16;
  localparam int MSQ_DEPTH_DEFAULT    = 4;

  typedef enum logic [1:0] {
    MSQ_INVALID = 2'd0,
    MSQ_PENDING = 2'd1,
    MSQ_WAIT    = 2'd2,
    MSQ_FILL    = 2'd3
  } msq_state_t;

  typedef logic [$clog2(MSQ_DEPTH_DEFAULT)-1:0] msq_idx_t;
  typedef logic [8*DC_LINE_SIZE_DEFAULT-1:0]    dc_line_t;

  // Clear the byte-offset bits of an address to get its line address.
  function automatic logic [31:0] line_align(input logic [31:0] addr, input int offset);
    return (addr >> offset) << offset;
  endfunction

endpackage

// File: rtl/dcache_msq_if.sv
// Bus bundle between the miss status queue and its neighbours: store-retire
// port, memory read request/response channel and cache fill write port.
interface dcache_msq_if #(
  parameter int MSQ_DEPTH    = 4,
  parameter int DC_LINE_SIZE = 16
);
  localparam int IDX_W  = $clog2(MSQ_DEPTH);
  localparam int LINE_W = 8 * DC_LINE_SIZE;

  logic              i_sq_retire_en;
  logic [3:0]        i_sq_retire_byte_en;
  logic [31:0]       i_sq_retire_addr;
  logic [31:0]       i_sq_retire_data;
  logic              i_sq_retire_dc_hit;
  logic              o_sq_retire_msq_full;
  logic              o_mem_req_valid;
  logic [31:0]       o_mem_req_addr;
  logic [IDX_W-1:0]  o_mem_req_id;
  logic              i_mem_req_ready;
  logic              i_mem_rsp_valid;
  logic [IDX_W-1:0]  i_mem_rsp_id;
  logic [LINE_W-1:0] i_mem_rsp_data;
  logic              o_fill_en;
  logic [31:0]       o_fill_addr;
  logic [LINE_W-1:0] o_fill_data;

  // The queue itself.
  modport slave (
    input  i_sq_retire_en, i_sq_retire_byte_en, i_sq_retire_addr, i_sq_retire_data,
    input  i_sq_retire_dc_hit, i_mem_req_ready, i_mem_rsp_valid, i_mem_rsp_id, i_mem_rsp_data,
    output o_sq_retire_msq_full, o_mem_req_valid, o_mem_req_addr, o_mem_req_id,
    output o_fill_en, o_fill_addr, o_fill_data
  );

  // The surrounding store queue / memory / cache array.
  modport master (
    output i_sq_retire_en, i_sq_retire_byte_en, i_sq_retire_addr, i_sq_retire_data,
    output i_sq_retire_dc_hit, i_mem_req_ready, i_mem_rsp_valid, i_mem_rsp_id, i_mem_rsp_data,
    input  o_sq_retire_msq_full, o_mem_req_valid, o_mem_req_addr, o_mem_req_id,
    input  o_fill_en, o_fill_addr, o_fill_data
  );
endinterface

// File: rtl/dcache_msq_line_merge.sv
// Byte-granular merge: each byte whose select bit is set comes from the new
// line, every other byte from the old line. Used both for folding store bytes
// into an entry and for laying store bytes over returned fill data.
module msq_line_merge #(
  parameter int NBYTES = 16
) (
  input  logic [8*NBYTES-1:0] old_line_i,
  input  logic [8*NBYTES-1:0] new_line_i,
  input  logic [NBYTES-1:0]   sel_i,
  output logic [8*NBYTES-1:0] line_o
);

  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte
    assign line_o[8*gi +: 8] = sel_i[gi] ? new_line_i[8*gi +: 8] : old_line_i[8*gi +: 8];
  end

endmodule

// File: rtl/dcache_msq.sv
// Miss status queue for retiring stores that miss the data cache.
// Optional build macro: DCACHE_MSQ_FILL_BYPASS_EN -- when defined, a memory
// response with no entry already in FILL is written to the cache in the same
// cycle and the entry goes straight from WAIT to INVALID.
module dcache_msq
  import dcache_msq_pkg::*;
#(
  parameter int MSQ_DEPTH    = MSQ_DEPTH_DEFAULT,
  parameter int DC_LINE_SIZE = DC_LINE_SIZE_DEFAULT
) (
  input logic        clk,
  input logic        n_rst,
  dcache_msq_if.slave bus
);

  localparam int OFFSET = $clog2(DC_LINE_SIZE);
  localparam int IDX_W  = $clog2(MSQ_DEPTH);
  localparam int LINE_W = 8 * DC_LINE_SIZE;
  localparam int WORDS  = DC_LINE_SIZE / 4;

  // Entry storage.
  msq_state_t              state_q [MSQ_DEPTH];
  logic [31:0]             addr_q  [MSQ_DEPTH];
  logic [LINE_W-1:0]       data_q  [MSQ_DEPTH];
  logic [DC_LINE_SIZE-1:0] mask_q  [MSQ_DEPTH];

  // Stalled-request hold so a newly allocated lower entry cannot swap the
  // request out from under the memory side.
  logic             req_lock_q;
  logic [IDX_W-1:0] req_idx_q;

  // Decoded store.
  logic [3:0]              lane4;
  logic [31:0]             data_sh;
  logic [31:0]             word_sel;
  logic [DC_LINE_SIZE-1:0] st_mask;
  logic [LINE_W-1:0]       st_data;
  logic [31:0]             st_line;

  // Searches and control.
  logic             miss, full, accept;
  logic             match_any, inval_any, pend_any, fill_any;
  logic [IDX_W-1:0] match_idx, free_idx, pend_idx, fill_idx;
  logic             req_valid, req_fire;
  logic [IDX_W-1:0] req_idx;
  logic             bypass;
  logic             fill_en;
  logic [IDX_W-1:0] fill_entry;

  // Per-entry merge results.
  logic [MSQ_DEPTH-1:0]    store_sel;
  logic [MSQ_DEPTH-1:0]    rsp_sel;
  logic [DC_LINE_SIZE-1:0] sel_mask     [MSQ_DEPTH];
  logic [DC_LINE_SIZE-1:0] mask_merged  [MSQ_DEPTH];
  logic [LINE_W-1:0]       st_merge_data  [MSQ_DEPTH];
  logic [LINE_W-1:0]       rsp_merge_data [MSQ_DEPTH];

  // Place the store's bytes at their lane and word within the line.
  always_comb begin
    lane4    = 4'({4'b0000, bus.i_sq_retire_byte_en} << bus.i_sq_retire_addr[1:0]);
    data_sh  = bus.i_sq_retire_data << {bus.i_sq_retire_addr[1:0], 3'b000};
    word_sel = (bus.i_sq_retire_addr >> 2) & 32'(WORDS - 1);
    st_mask  = DC_LINE_SIZE'(lane4) << {word_sel[29:0], 2'b00};
    st_data  = LINE_W'(data_sh) << {word_sel[26:0], 5'b00000};
    st_line  = line_align(bus.i_sq_retire_addr, OFFSET);
  end

  // Lowest-index searches over the entry table (scan high to low so the
  // lowest hit is the last one written).
  always_comb begin
    match_any = 1'b0; match_idx = '0;
    inval_any = 1'b0; free_idx  = '0;
    pend_any  = 1'b0; pend_idx  = '0;
    fill_any  = 1'b0; fill_idx  = '0;
    for (int i = MSQ_DEPTH - 1; i >= 0; i--) begin
      if (state_q[i] != MSQ_INVALID && addr_q[i] == st_line) begin
        match_any = 1'b1; match_idx = IDX_W'(i);
      end
      if (state_q[i] == MSQ_INVALID) begin
        inval_any = 1'b1; free_idx = IDX_W'(i);
      end
      if (state_q[i] == MSQ_PENDING) begin
        pend_any = 1'b1; pend_idx = IDX_W'(i);
      end
      if (state_q[i] == MSQ_FILL) begin
        fill_any = 1'b1; fill_idx = IDX_W'(i);
      end
    end
  end

  // Acceptance, request selection and fill-port selection.
  always_comb begin
    miss   = bus.i_sq_retire_en && !bus.i_sq_retire_dc_hit;
    full   = miss && ((match_any && state_q[match_idx] == MSQ_FILL) ||
                      (!match_any && !inval_any));
    accept = miss && !full;

    req_valid = req_lock_q || pend_any;
    req_idx   = req_lock_q ? req_idx_q : pend_idx;
    req_fire  = req_valid && bus.i_mem_req_ready;

`ifdef DCACHE_MSQ_FILL_BYPASS_EN
    bypass = bus.i_mem_rsp_valid && !fill_any && state_q[bus.i_mem_rsp_id] == MSQ_WAIT;
`else
    bypass = 1'b0;
`endif
    fill_en    = fill_any || bypass;
    fill_entry = fill_any ? fill_idx : bus.i_mem_rsp_id;
  end

  // Per entry: fold store bytes in, then lay the result over any fill data.
  for (genvar gi = 0; gi < MSQ_DEPTH; gi++) begin : g_entry
    assign store_sel[gi] = accept && (match_any ? (match_idx == IDX_W'(gi))
                                                : (free_idx == IDX_W'(gi)));
    assign rsp_sel[gi]   = bus.i_mem_rsp_valid && (bus.i_mem_rsp_id == IDX_W'(gi)) &&
                           (state_q[gi] == MSQ_WAIT);
    assign sel_mask[gi]    = store_sel[gi] ? st_mask : '0;
    assign mask_merged[gi] = mask_q[gi] | sel_mask[gi];

    msq_line_merge #(.NBYTES(DC_LINE_SIZE)) u_store_merge (
      .old_line_i (data_q[gi]),
      .new_line_i (st_data),
      .sel_i      (sel_mask[gi]),
      .line_o     (st_merge_data[gi])
    );

    msq_line_merge #(.NBYTES(DC_LINE_SIZE)) u_rsp_merge (
      .old_line_i (bus.i_mem_rsp_data),
      .new_line_i (st_merge_data[gi]),
      .sel_i      (mask_merged[gi]),
      .line_o     (rsp_merge_data[gi])
    );
  end

  // Entry state machine plus the stalled-request hold.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < MSQ_DEPTH; i++) begin
        state_q[i] <= MSQ_INVALID;
        addr_q[i]  <= '0;
        data_q[i]  <= '0;
        mask_q[i]  <= '0;
      end
      req_lock_q <= 1'b0;
      req_idx_q  <= '0;
    end else begin
      for (int i = 0; i < MSQ_DEPTH; i++) begin
        if (fill_en && fill_entry == IDX_W'(i)) begin
          state_q[i] <= MSQ_INVALID;
          mask_q[i]  <= '0;
        end else if (rsp_sel[i]) begin
          state_q[i] <= MSQ_FILL;
          data_q[i]  <= rsp_merge_data[i];
          mask_q[i]  <= mask_merged[i];
        end else begin
          if (store_sel[i]) begin
            data_q[i] <= st_merge_data[i];
            mask_q[i] <= mask_merged[i];
            if (state_q[i] == MSQ_INVALID) begin
              state_q[i] <= MSQ_PENDING;
              addr_q[i]  <= st_line;
            end
          end
          if (req_fire && req_idx == IDX_W'(i)) begin
            state_q[i] <= MSQ_WAIT;
          end
        end
      end
      req_lock_q <= req_valid && !bus.i_mem_req_ready;
      req_idx_q  <= req_idx;
    end
  end

  // Output drive; idle ports read zero.
  always_comb begin
    bus.o_sq_retire_msq_full = full;
    bus.o_mem_req_valid      = req_valid;
    bus.o_mem_req_addr       = req_valid ? addr_q[req_idx] : '0;
    bus.o_mem_req_id         = req_valid ? req_idx : '0;
    bus.o_fill_en            = fill_en;
    bus.o_fill_addr          = fill_en ? addr_q[fill_entry] : '0;
    bus.o_fill_data          = '0;
    if (fill_en) begin
      bus.o_fill_data = fill_any ? data_q[fill_idx] : rsp_merge_data[bus.i_mem_rsp_id];
    end
  end

endmodule

// File: tb/tb_dcache_msq.sv
// Directed bench for the miss status queue: allocation, merging, full
// back-pressure, response/store collision, FILL stall, hits and reset.
module tb_dcache_msq;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  dcache_msq_if #(.MSQ_DEPTH(4), .DC_LINE_SIZE(16)) bus ();

  dcache_msq #(.MSQ_DEPTH(4), .DC_LINE_SIZE(16)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] data, input logic hit);
    bus.i_sq_retire_en      = 1'b1;
    bus.i_sq_retire_addr    = addr;
    bus.i_sq_retire_byte_en = be;
    bus.i_sq_retire_data    = data;
    bus.i_sq_retire_dc_hit  = hit;
  endtask

  task automatic no_store();
    bus.i_sq_retire_en     = 1'b0;
    bus.i_sq_retire_dc_hit = 1'b0;
  endtask

  task automatic rsp(input logic v, input logic [1:0] id, input logic [7:0] fill_byte);
    bus.i_mem_rsp_valid = v;
    bus.i_mem_rsp_id    = id;
    bus.i_mem_rsp_data  = {16{fill_byte}};
  endtask

  // Move to the next cycle: inputs change at the falling edge, checks follow.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #2;
    $display("t=%0t full=%0b req=%0b/%h/%0d fill=%0b/%h/%h", $time,
             bus.o_sq_retire_msq_full, bus.o_mem_req_valid, bus.o_mem_req_addr,
             bus.o_mem_req_id, bus.o_fill_en, bus.o_fill_addr, bus.o_fill_data);
  endtask

  initial begin
    no_store();
    bus.i_sq_retire_addr    = '0;
    bus.i_sq_retire_byte_en = '0;
    bus.i_sq_retire_data    = '0;
    bus.i_mem_req_ready     = 1'b1;
    rsp(1'b0, 2'd0, 8'h00);

    // Reset state.
    repeat (2) step();
    settle();
    chk("rst_full", 128'(bus.o_sq_retire_msq_full), 128'd0);
    chk("rst_req_valid", 128'(bus.o_mem_req_valid), 128'd0);
    chk("rst_req_addr", 128'(bus.o_mem_req_addr), 128'd0);
    chk("rst_fill_en", 128'(bus.o_fill_en), 128'd0);
    n_rst = 1'b1;

    // Miss allocation.
    step(); store(32'h1004, 4'b1111, 32'hDEADBEEF, 1'b0); settle();
    chk("alloc_full", 128'(bus.o_sq_retire_msq_full), 128'd0);
    chk("alloc_no_req_yet", 128'(bus.o_mem_req_valid), 128'd0);
    step(); no_store(); settle();
    chk("alloc_req_valid", 128'(bus.o_mem_req_valid), 128'd1);
    chk("alloc_req_addr", 128'(bus.o_mem_req_addr), 128'h1000);
    chk("alloc_req_id", 128'(bus.o_mem_req_id), 128'd0);

    // Merges into the waiting entry.
    step(); store(32'h1001, 4'b0001, 32'h000000AA, 1'b0); settle();
    chk("merge_sb_full", 128'(bus.o_sq_retire_msq_full), 128'd0);
    chk("merge_sb_no_req", 128'(bus.o_mem_req_valid), 128'd0);
    step(); store(32'h100E, 4'b0011, 32'h0000BBCC, 1'b0); settle();
    chk("merge_sh_full", 128'(bus.o_sq_retire_msq_full), 128'd0);
    chk("merge_sh_no_req", 128'(bus.o_mem_req_valid), 128'd0);
    step(); no_store(); rsp(1'b1, 2'd0, 8'h11); settle();
    chk("rsp0_no_fill_yet", 128'(bus.o_fill_en), 128'd0);
    step(); rsp(1'b0, 2'd0, 8'h00); settle();
    chk("fill0_en", 128'(bus.o_fill_en), 128'd1);
    chk("fill0_addr", 128'(bus.o_fill_addr), 128'h1000);
    chk("fill0_data", bus.o_fill_data, 128'hBBCC1111_11111111_DEADBEEF_1111AA11);
    step(); settle();
    chk("fill0_one_cycle", 128'(bus.o_fill_en), 128'd0);

    // Fill the queue with memory stalled.
    bus.i_mem_req_ready = 1'b0;
    step(); store(32'h2000, 4'b1111, 32'hA0A0A0A0, 1'b0); settle();
    chk("full_a0", 128'(bus.o_sq_retire_msq_full), 128'd0);
    step(); store(32'h3000, 4'b1111, 32'h12345678, 1'b0); settle();
    chk("full_a1", 128'(bus.o_sq_retire_msq_full), 128'd0);
    chk("stall_req_addr", 128'(bus.o_mem_req_addr), 128'h2000);
    step(); store(32'h4004, 4'b1111, 32'hCAFEF00D, 1'b0); settle();
    chk("full_a2", 128'(bus.o_sq_retire_msq_full), 128'd0);
    step(); store(32'h5000, 4'b1111, 32'h55555555, 1'b0); settle();
    chk("full_a3", 128'(bus.o_sq_retire_msq_full), 128'd0);
    step(); store(32'h6000, 4'b1111, 32'h66666666, 1'b0); settle();
    chk("full_fifth_miss", 128'(bus.o_sq_retire_msq_full), 128'd1);
    chk("stall_req_id", 128'(bus.o_mem_req_id), 128'd0);
    chk("stall_req_addr2", 128'(bus.o_mem_req_addr), 128'h2000);
    step(); store(32'h3008, 4'b1111, 32'h33333333, 1'b0); settle();
    chk("full_match_merge", 128'(bus.o_sq_retire_msq_full), 128'd0);
    step(); store(32'h7000, 4'b1111, 32'h77777777, 1'b1); settle();
    chk("full_hit_never_full", 128'(bus.o_sq_retire_msq_full), 128'd0);

    // Release memory: requests drain in index order.
    step(); no_store(); bus.i_mem_req_ready = 1'b1; settle();
    chk("drain_id0", 128'(bus.o_mem_req_id), 128'd0);
    step(); settle();
    chk("drain_id1", 128'(bus.o_mem_req_id), 128'd1);
    chk("drain_addr1", 128'(bus.o_mem_req_addr), 128'h3000);
    step(); settle();
    chk("drain_id2", 128'(bus.o_mem_req_id), 128'd2);
    step(); settle();
    chk("drain_id3", 128'(bus.o_mem_req_id), 128'd3);
    chk("drain_addr3", 128'(bus.o_mem_req_addr), 128'h5000);

    // Store and response to entry 2 in the same cycle.
    step(); store(32'h4004, 4'b1111, 32'h77777777, 1'b0); rsp(1'b1, 2'd2, 8'h22); settle();
    chk("coll_full", 128'(bus.o_sq_retire_msq_full), 128'd0);
    chk("coll_no_req", 128'(bus.o_mem_req_valid), 128'd0);
    step(); no_store(); rsp(1'b0, 2'd0, 8'h00); settle();
    chk("coll_fill_en", 128'(bus.o_fill_en), 128'd1);
    chk("coll_fill_addr", 128'(bus.o_fill_addr), 128'h4000);
    chk("coll_fill_data", bus.o_fill_data, 128'h22222222_22222222_77777777_22222222);

    // Store to a line whose entry is in FILL stalls, then retries.
    step(); rsp(1'b1, 2'd1, 8'h44); settle();
    chk("stall_rsp_no_fill", 128'(bus.o_fill_en), 128'd0);
    step(); rsp(1'b0, 2'd0, 8'h00); store(32'h3004, 4'b1111, 32'h99999999, 1'b0); settle();
    chk("fillst_full", 128'(bus.o_sq_retire_msq_full), 128'd1);
    chk("fillst_fill_en", 128'(bus.o_fill_en), 128'd1);
    chk("fillst_fill_data", bus.o_fill_data, 128'h44444444_33333333_44444444_12345678);
    step(); settle();
    chk("retry_full", 128'(bus.o_sq_retire_msq_full), 128'd0);
    chk("retry_no_fill", 128'(bus.o_fill_en), 128'd0);
    step(); no_store(); settle();
    chk("retry_req_valid", 128'(bus.o_mem_req_valid), 128'd1);
    chk("retry_req_id", 128'(bus.o_mem_req_id), 128'd1);
    chk("retry_req_addr", 128'(bus.o_mem_req_addr), 128'h3000);

    // Reset with entries in WAIT, then a late response.
    step(); n_rst = 1'b0; settle();
    chk("midrst_req_valid", 128'(bus.o_mem_req_valid), 128'd0);
    step(); n_rst = 1'b1; rsp(1'b1, 2'd0, 8'h66); settle();
    chk("late_rsp_no_fill", 128'(bus.o_fill_en), 128'd0);
    step(); rsp(1'b0, 2'd0, 8'h00); settle();
    chk("late_rsp_no_fill2", 128'(bus.o_fill_en), 128'd0);

    // Hits never allocate.
    step(); store(32'h8000, 4'b1111, 32'h01020304, 1'b1); settle();
    chk("hit_full", 128'(bus.o_sq_retire_msq_full), 128'd0);
    step(); no_store(); settle();
    chk("hit_no_alloc", 128'(bus.o_mem_req_valid), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dcache_msq.md
Name: dcache_msq

Overview:
- Miss status queue on the data-cache side of the store-retire interface. It is the responder to the LSU store queue's retire port.
- A retiring store that misses the cache is allocated into, or merged into, a line-sized entry. The block then fetches the line from memory, merges the store bytes over the fill data, and writes the completed line into the cache array.
- It drives the full signal that the store queue samples in the same cycle as its retire request.

Parameters:
- MSQ_DEPTH, 4, number of line entries; must be a power of 2 and ≥2.
- DC_LINE_SIZE, 16, bytes per cache line; must be a power of 2 and ≥4.

Ports:
- clk  in  1  clock
- n_rst  in  1  asynchronous active-low reset
- i_sq_retire_en  in  1  store retire request
- i_sq_retire_byte_en  in  4  byte enables, word-relative (0001 = SB, 0011 = SH, 1111 = SW)
- i_sq_retire_addr  in  32  store byte address
- i_sq_retire_data  in  32  store data, right-justified
- i_sq_retire_dc_hit  in  1  cache tag hit for this store, from the cache array
- o_sq_retire_msq_full  out  1  miss not accepted this cycle; the store queue retries
- o_mem_req_valid  out  1  line read request
- o_mem_req_addr  out  32  line-aligned address
- o_mem_req_id  out  log2(MSQ_DEPTH)  entry index
- i_mem_req_ready  in  1  request accepted when both valid and ready are high
- i_mem_rsp_valid  in  1  fill data returned
- i_mem_rsp_id  in  log2(MSQ_DEPTH)  entry index of the fill
- i_mem_rsp_data  in  8*DC_LINE_SIZE  line data
- o_fill_en  out  1  write a completed line into the cache
- o_fill_addr  out  32  line-aligned address
- o_fill_data  out  8*DC_LINE_SIZE  merged line data

Behaviour:
- Entry fields: state, line address, line data, byte mask (DC_LINE_SIZE bits).
- Entry states: INVALID, PENDING (request not yet sent), WAIT (request sent), FILL (line complete).
- Reset: all entries INVALID, masks 0. All outputs read 0; o_sq_retire_msq_full reads 0 because no request is present.
- Byte placement:
  - lane = byte_en << addr[1:0], placed at word offset addr[OFFSET-1:2], where OFFSET = log2(DC_LINE_SIZE).
  - Data is shifted left by 8*addr[1:0].
  - Lanes beyond the word are dropped; the LSU guarantees aligned stores.
- miss = i_sq_retire_en && !i_sq_retire_dc_hit.
- Match is computed combinationally: any non-INVALID entry whose line address equals the store's line address. At most one entry matches.
- o_sq_retire_msq_full is combinational and is asserted when miss and either:
  - the matching entry is in FILL, or
  - there is no match and no INVALID entry.
  - Otherwise it is 0. It is never asserted on a hit or when there is no request.
- Accept (miss && !full):
  - Match in PENDING or WAIT: merge the enabled bytes into the entry's data and OR the lanes into its mask at the next edge.
  - No match: allocate the lowest-index INVALID entry into PENDING, with the new bytes and mask.
- Memory request:
  - The lowest-index PENDING entry drives o_mem_req_*.
  - On valid && ready the entry moves to WAIT at the next edge.
  - While the request is stalled, valid, address and id stay stable.
- Memory response:
  - i_mem_rsp_valid moves entry i_mem_rsp_id from WAIT to FILL.
  - Stored data is taken from the response for unmasked bytes only; masked bytes keep the store data.
  - A response for an entry not in WAIT is ignored.
- Same-cycle store merge and response to the same entry: the incoming store bytes win over response data, and the entry still moves to FILL.
- Fill output:
  - The lowest-index FILL entry drives o_fill_en/addr/data combinationally for one cycle.
  - The entry becomes INVALID at the next edge and its mask clears.
  - One fill per cycle.
- A freed entry may be reallocated in the cycle after its fill. In the fill cycle itself it still counts as occupied, and a store to that line sees full=1.
- Latency with i_mem_req_ready=1: store accept at cycle 0, request at cycle 1, earliest fill write one cycle after the response.
- Reset mid-operation discards all entries. Outstanding memory responses after reset are ignored because no entry is in WAIT.
- No flush input: retired stores are architecturally committed.

Optional Feature:
- Macro: DCACHE_MSQ_FILL_BYPASS_EN.
- Defined:
  - When i_mem_rsp_valid is high and no entry is in FILL, the merged line drives o_fill_* in the same cycle.
  - The entry goes directly WAIT→INVALID, saving one cycle.
  - A same-cycle store merge into that entry is also included in the bypassed data.
- Undefined: the response always goes through the FILL state, as described in Behaviour.

Decomposition:
- Shared package procyon_types gets:
  - msq_state_t enum (INVALID, PENDING, WAIT, FILL)
  - msq_idx_t
  - dc_line_t (8*DC_LINE_SIZE bits)
  - DC_LINE_SIZE and MSQ_DEPTH defaults in common.svh
- One sub-module, msq_line_merge: combinational byte-mask merge of a new byte array over an old line. It is reused for the store merge and the response merge.

Test Plan:
- Miss alloc:
  - Stimulus: SW 0xDEADBEEF @0x1004, dc_hit=0, ready=1; response id0 data all 0x11.
  - Required: full=0; req addr 0x1000 id0 at the next cycle.
  - Required fill data: word1 = 0xDEADBEEF, other bytes 0x11.
- Merge:
  - Stimulus: SB 0xAA @0x1001, then SH 0xBBCC @0x100E, both while entry0 is in WAIT.
  - Required: a single request is issued; the fill has byte1 = 0xAA and bytes14–15 = 0xBBCC.
- Full:
  - Stimulus: 4 misses to distinct lines with ready=0, then a 5th miss.
  - Required: full=1 on the 5th miss; a miss to an already-allocated line in the same cycle gets full=0.
- Collision:
  - Stimulus: response id2 arrives in the same cycle as an SW to entry2's line.
  - Required: the fill contains the store word, not the response word.
- FILL-state stall:
  - Stimulus: a store to a line whose entry is in FILL.
  - Required: full=1 that cycle; the retry next cycle allocates a new entry.
- Reset/hit:
  - Stimulus: dc_hit=1 stores.
  - Required: no allocation and full=0.
  - Stimulus: n_rst pulse with entries in WAIT, then a late response.
  - Required: no fill issued.
